// File: rtl/wb_port_arbiter.sv
// Two-requester writeback arbiter onto the single regfile write port, oldest-first.
// Latency: accepted at edge N, written in cycle N+1 at the earliest; ready drops while a slot holds an ungranted entry.
module wb_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1,
    output logic              busy2
);

    logic              alu_hold_v;
    logic [ADDR_W-1:0] alu_hold_addr;
    logic [DATA_W-1:0] alu_hold_data;
    logic              mem_hold_v;
    logic [ADDR_W-1:0] mem_hold_addr;
    logic [DATA_W-1:0] mem_hold_data;
    logic              mem_older;

    logic alu_granted;
    logic mem_granted;
    logic alu_accept;
    logic mem_accept;
    logic alu_load;
    logic mem_load;

    // mem_older only matters when both slots are held
    assign alu_granted = alu_hold_v & (!mem_hold_v | !mem_older);
    assign mem_granted = mem_hold_v & (!alu_hold_v | mem_older);

    assign alu_ready = rst & (!alu_hold_v | alu_granted);
    assign mem_ready = rst & (!mem_hold_v | mem_granted);

    assign alu_accept = alu_valid & alu_ready;
    assign mem_accept = mem_valid & mem_ready;

    // Writes to x0 complete the handshake but are never held
    assign alu_load = alu_accept & (alu_addr != '0);
    assign mem_load = mem_accept & (mem_addr != '0);

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (rst && mem_granted) begin
            we    = 1'b1;
            waddr = mem_hold_addr;
            wdata = mem_hold_data;
        end else if (rst && alu_granted) begin
            we    = 1'b1;
            waddr = alu_hold_addr;
            wdata = alu_hold_data;
        end
    end

    // The entry being written this cycle still counts; the regfile forwards it
    assign busy1 = rst & (raddr1 != '0) &
                   ((alu_hold_v & (alu_hold_addr == raddr1)) |
                    (mem_hold_v & (mem_hold_addr == raddr1)));
    assign busy2 = rst & (raddr2 != '0) &
                   ((alu_hold_v & (alu_hold_addr == raddr2)) |
                    (mem_hold_v & (mem_hold_addr == raddr2)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_hold_v <= 1'b0;
            mem_hold_v <= 1'b0;
            mem_older  <= 1'b0;
        end else begin
            if (alu_accept) begin
                alu_hold_v <= alu_load;
            end else if (alu_granted) begin
                alu_hold_v <= 1'b0;
            end

            if (mem_accept) begin
                mem_hold_v <= mem_load;
            end else if (mem_granted) begin
                mem_hold_v <= 1'b0;
            end

            // A fresh load is younger than whatever remains; same-edge loads make mem older
            if (alu_load) begin
                mem_older <= 1'b1;
            end else if (mem_load) begin
                mem_older <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alu_accept) begin
            alu_hold_addr <= alu_addr;
            alu_hold_data <= alu_data;
        end
        if (mem_accept) begin
            mem_hold_addr <= mem_addr;
            mem_hold_data <= mem_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scenario bench for wb_port_arbiter: expected writes are queued in issue order and
// matched against the write port at every falling edge.
module tb_wb_port_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        busy1;
    logic        busy2;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [31:0] regs [0:31];

    wb_port_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .busy1(busy1), .busy2(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (we !== 1'b0) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: we=%b waddr=%0d wdata=%h, required no write", we, waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                if (waddr !== e.addr || wdata !== e.data) begin
                    errors++;
                    $display("FAIL write_order: got x%0d=%h, required x%0d=%h", waddr, wdata, e.addr, e.data);
                end
            end
            regs[waddr] = wdata;
        end
    end

    task automatic idle_inputs();
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hDEAD0007;
        mem_valid = 1'b1; mem_addr = 5'd8; mem_data = 32'hDEAD0008;
        raddr1 = 5'd7; raddr2 = 5'd8;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({we, alu_ready, mem_ready, busy1, busy2} !== 5'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs: we=%b ardy=%b mrdy=%b b1=%b b2=%b waddr=%0d wdata=%h, required all 0",
                         we, alu_ready, mem_ready, busy1, busy2, waddr, wdata);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ardy=%b mrdy=%b we=%b, required 1 1 0", alu_ready, mem_ready, we);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        raddr1 = 5'd5;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h00001234;
        exp_q.push_back('{addr: 5'd5, data: 32'h00001234});
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (we !== 1'b1 || waddr !== 5'd5 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL single_n1: we=%b waddr=%0d busy1=%b, required 1 5 1", we, waddr, busy1);
        end
        @(negedge clk);
        checks++;
        if (we !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL single_n2: we=%b busy1=%b, required 0 0", we, busy1);
        end
        wait_drain("single");
    endtask

    task automatic test_contention();
        @(posedge clk); #1;
        raddr1 = 5'd3; raddr2 = 5'd4;
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'hAAAA0000;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h0000BBBB;
        exp_q.push_back('{addr: 5'd3, data: 32'hAAAA0000});
        exp_q.push_back('{addr: 5'd4, data: 32'h0000BBBB});
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (waddr !== 5'd3 || alu_ready !== 1'b0 || mem_ready !== 1'b1 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL contention_c1: waddr=%0d ardy=%b mrdy=%b b1=%b b2=%b, required 3 0 1 1 1",
                     waddr, alu_ready, mem_ready, busy1, busy2);
        end
        @(negedge clk);
        checks++;
        if (waddr !== 5'd4 || alu_ready !== 1'b1 || busy1 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL contention_c2: waddr=%0d ardy=%b b1=%b b2=%b, required 4 1 0 1",
                     waddr, alu_ready, busy1, busy2);
        end
        wait_drain("contention");
    endtask

    task automatic test_ordering();
        logic [2:0] busy_seen;
        @(posedge clk); #1;
        raddr1 = 5'd6; raddr2 = 5'd2;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'd1;
        alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'd7;
        exp_q.push_back('{addr: 5'd2, data: 32'd1});
        exp_q.push_back('{addr: 5'd6, data: 32'd7});
        exp_q.push_back('{addr: 5'd6, data: 32'd9});
        @(posedge clk); #1;
        alu_valid = 1'b0;
        mem_addr = 5'd6; mem_data = 32'd9;
        @(negedge clk);
        checks++;
        if (mem_ready !== 1'b1 || waddr !== 5'd2 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL order_reload: mrdy=%b waddr=%0d busy2=%b, required 1 2 1", mem_ready, waddr, busy2);
        end
        busy_seen[0] = busy1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk); busy_seen[1] = busy1;
        @(negedge clk); busy_seen[2] = busy1;
        checks++;
        if (busy_seen !== 3'b111) begin
            errors++;
            $display("FAIL order_busy: busy1 over N+1..N+3=%b, required 111", busy_seen);
        end
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL order_busy_clear: busy1=%b, required 0", busy1);
        end
        wait_drain("ordering");
        checks++;
        if (regs[6] !== 32'd9) begin
            errors++;
            $display("FAIL order_final: x6=%h, required 9", regs[6]);
        end
    endtask

    task automatic test_x0_drop();
        @(posedge clk); #1;
        raddr1 = 5'd0; raddr2 = 5'd0;
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready_pre: alu_ready=%b, required 1", alu_ready);
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (alu_ready !== 1'b1 || we !== 1'b0 || busy1 !== 1'b0) begin
                errors++;
                $display("FAIL x0_drop: ardy=%b we=%b busy1=%b, required 1 0 0", alu_ready, we, busy1);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        raddr1 = 5'd8; raddr2 = 5'd9;
        alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h08080808;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h09090909;
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (we !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_hold: we=%b b1=%b b2=%b, required 0 0 0", we, busy1, busy2);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (we !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_release: we=%b b1=%b b2=%b mrdy=%b, required 0 0 0 1",
                     we, busy1, busy2, mem_ready);
        end
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'h0000000A;
        exp_q.push_back('{addr: 5'd10, data: 32'h0000000A});
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (we !== 1'b1 || waddr !== 5'd10) begin
            errors++;
            $display("FAIL midreset_fresh: we=%b waddr=%0d, required 1 10", we, waddr);
        end
        wait_drain("midreset");
    endtask

    initial begin
        rst = 1'b0;
        raddr1 = '0; raddr2 = '0;
        idle_inputs();
        for (int i = 0; i < 32; i++) regs[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_ordering();
        test_x0_drop();
        test_reset_mid();
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
